// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            div_by_zero,
  output logic            overflow_flag
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_res_q, neg_rem_q;
  logic              busy_q, done_q, zero_q, dbz_q, ovf_q;
  logic [XLEN-1:0]   result_q;

  // Operand decode at acceptance: signedness, magnitudes and fast-path detection.
  logic            signed_a, signed_b, neg_a, neg_b, is_dbz, is_ovf;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  always_comb begin
    signed_a = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    signed_b = op[2] ? ~op[0] : ~op[1];
    neg_a    = signed_a & operand_a[XLEN-1];
    neg_b    = signed_b & operand_b[XLEN-1];
    mag_a    = neg_a ? -operand_a : operand_a;
    mag_b    = neg_b ? -operand_b : operand_b;
    is_dbz   = op[2] && (operand_b == '0);
    is_ovf   = op[2] && !op[0] && (operand_a == MOST_NEG) && (operand_b == ALL_ONES);
    fast_res = is_dbz ? (op[1] ? operand_a : ALL_ONES) : (op[1] ? '0 : operand_a);
  end

  // One iteration step; multiply keeps {hi, multiplier}, divide keeps {remainder, quotient}.
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic              ge;
  logic [2*XLEN-1:0] acc_d, prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = rem_sh - {1'b0, opnd_q};
    ge      = ~diff[XLEN];
    if (op_q[2]) acc_d = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    else         acc_d = {mul_sum, acc_q[XLEN-1:1]};
    prod = neg_res_q ? -acc_d : acc_d;
    quo  = neg_res_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem  = neg_rem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        final_res = quo;
      default:               final_res = rem;
    endcase
  end

  // NOTE: every register here uses <= so all of them sample pre-edge values,
  // independent of statement order inside this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_res;
            zero_q   <= (final_res == '0);
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise.
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          if (start) begin
            op_q      <= op;
            neg_res_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            if (is_dbz || is_ovf) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= fast_res;
              zero_q   <= (fast_res == '0);
              dbz_q    <= is_dbz;
              ovf_q    <= is_ovf;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              acc_q   <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
              opnd_q  <= op[2] ? mag_b : mag_a;
            end
          end
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign zero_flag     = zero_q;
  assign div_by_zero   = dbz_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=8: stimulus pushes model
// predictions, independent monitors pop and compare on every done pulse.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    logic        zf, dbz, ovf;
    int unsigned push_cyc;
    int          lat, busy_cyc;
    string       tag;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  // XLEN=32 instance
  logic        rst, start, busy, done, zf, dbz, ovf;
  logic [2:0]  op;
  logic [31:0] a, b, res;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand_a(a), .operand_b(b),
    .busy(busy), .done(done), .result(res), .zero_flag(zf),
    .div_by_zero(dbz), .overflow_flag(ovf)
  );

  // XLEN=8 instance
  logic       rst8, start8, busy8, done8, zf8, dbz8, ovf8;
  logic [2:0] op8;
  logic [7:0] a8, b8, res8;

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .op(op8), .operand_a(a8), .operand_b(b8),
    .busy(busy8), .done(done8), .result(res8), .zero_flag(zf8),
    .div_by_zero(dbz8), .overflow_flag(ovf8)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic flag_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: plain 64-bit arithmetic on sign- or zero-extended w-bit operands.
  function automatic exp_t model(input int w, input logic [2:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] mask, ua, ub, p, r;
    longint      sa, sb, most_neg;
    mask     = (64'd1 << w) - 64'd1;
    ua       = {32'd0, x} & mask;
    ub       = {32'd0, y} & mask;
    sa       = $signed(ua << (64 - w)) >>> (64 - w);
    sb       = $signed(ub << (64 - w)) >>> (64 - w);
    most_neg = -(longint'(1) << (w - 1));
    e.dbz      = 1'b0;
    e.ovf      = 1'b0;
    e.lat      = w + 1;
    e.busy_cyc = w;
    e.push_cyc = 0;
    e.tag      = "";
    r          = '0;
    case (o)
      3'b000: begin p = sa * sb;           r = p; end
      3'b001: begin p = sa * sb;           r = p >> w; end
      3'b010: begin p = sa * longint'(ub); r = p >> w; end
      3'b011: begin p = ua * ub;           r = p >> w; end
      default: begin
        if (ub == 64'd0) begin
          e.dbz = 1'b1;
          r = o[1] ? ua : mask;
        end else if (!o[0] && sa == most_neg && sb == -1) begin
          e.ovf = 1'b1;
          r = o[1] ? 64'd0 : ua;
        end else if (!o[0]) begin
          r = o[1] ? sa % sb : sa / sb;
        end else begin
          r = o[1] ? ua % ub : ua / ub;
        end
        if (e.dbz || e.ovf) begin
          e.lat      = 1;
          e.busy_cyc = 0;
        end
      end
    endcase
    e.res = 32'(r & mask);
    e.zf  = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_opnd(input int w);
    logic [31:0] mask;
    mask = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return mask;
      2:       return 32'd1 << (w - 1);
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom & mask;
    endcase
  endfunction

  // Called on a negedge; waits for the unit to be free, then presents start for one edge.
  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
    exp_t e;
    int   guard = 0;
    while (busy === 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) flag_timeout({tag, "_issue"});
    e = model(32, o, x, y);
    e.tag = tag;
    e.push_cyc = cyc;
    q32.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input string tag);
    exp_t e;
    int   guard = 0;
    while (busy8 === 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) flag_timeout({tag, "_issue"});
    e = model(8, o, {24'd0, x}, {24'd0, y});
    e.tag = tag;
    e.push_cyc = cyc;
    q8.push_back(e);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drain32(input string tag);
    int guard = 0;
    while (q32.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) flag_timeout({tag, "_drain"});
  endtask

  task automatic drain8(input string tag);
    int guard = 0;
    while (q8.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) flag_timeout({tag, "_drain"});
  endtask

  // Monitors: compare on every done pulse, away from the active edge.
  exp_t m32_e, m8_e;
  int   busy_run32 = 0, busy_run8 = 0;

  always @(negedge clk) begin
    if (rst) begin
      busy_run32 = 0;
    end else begin
      if (busy) busy_run32++;
      if (done) begin
        if (q32.size() == 0) begin
          check("x32_unexpected_done", 32'(done), 32'd0);
        end else begin
          m32_e = q32.pop_front();
          check({m32_e.tag, "_result"}, res, m32_e.res);
          check({m32_e.tag, "_zero_flag"}, 32'(zf), 32'(m32_e.zf));
          check({m32_e.tag, "_div_by_zero"}, 32'(dbz), 32'(m32_e.dbz));
          check({m32_e.tag, "_overflow"}, 32'(ovf), 32'(m32_e.ovf));
          check({m32_e.tag, "_latency"}, cyc - m32_e.push_cyc, 32'(m32_e.lat));
          check({m32_e.tag, "_busy_cycles"}, 32'(busy_run32), 32'(m32_e.busy_cyc));
          check({m32_e.tag, "_busy_with_done"}, 32'(busy), 32'd0);
        end
        busy_run32 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst8) begin
      busy_run8 = 0;
    end else begin
      if (busy8) busy_run8++;
      if (done8) begin
        if (q8.size() == 0) begin
          check("x8_unexpected_done", 32'(done8), 32'd0);
        end else begin
          m8_e = q8.pop_front();
          check({m8_e.tag, "_result"}, {24'd0, res8}, m8_e.res);
          check({m8_e.tag, "_zero_flag"}, 32'(zf8), 32'(m8_e.zf));
          check({m8_e.tag, "_div_by_zero"}, 32'(dbz8), 32'(m8_e.dbz));
          check({m8_e.tag, "_overflow"}, 32'(ovf8), 32'(m8_e.ovf));
          check({m8_e.tag, "_latency"}, cyc - m8_e.push_cyc, 32'(m8_e.lat));
          check({m8_e.tag, "_busy_cycles"}, 32'(busy_run8), 32'(m8_e.busy_cyc));
          check({m8_e.tag, "_busy_with_done"}, 32'(busy8), 32'd0);
        end
        busy_run8 = 0;
      end
    end
  end

  task automatic check_reset32(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, res, 32'd0);
    check({tag, "_zero_flag"}, 32'(zf), 32'd0);
    check({tag, "_div_by_zero"}, 32'(dbz), 32'd0);
    check({tag, "_overflow"}, 32'(ovf), 32'd0);
  endtask

  task automatic seq32();
    // Directed cases from the arithmetic corner list.
    issue32(3'b000, 32'd7, 32'd6, "mul_7x6");
    issue32(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    issue32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    issue32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
    issue32(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
    issue32(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    issue32(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    issue32(3'b101, 32'd100, 32'd7, "divu_100_7");
    issue32(3'b111, 32'd100, 32'd7, "remu_100_7");
    issue32(3'b110, 32'd6, 32'd3, "rem_6_3");
    issue32(3'b100, 32'd5, 32'd0, "div_by0");
    issue32(3'b110, 32'd5, 32'd0, "rem_by0");
    issue32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    issue32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    drain32("directed");

    // A start pulse while busy must be ignored.
    issue32(3'b100, 32'd1000, 32'd7, "intf_div");
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    drain32("intf");

    // Reset mid-operation (with a coincident start) aborts without a done pulse.
    issue32(3'b100, 32'd12345, 32'd11, "aborted_div");
    repeat (9) @(negedge clk);
    q32.delete();
    rst = 1'b1; start = 1'b1; op = 3'b100; a = 32'd9; b = 32'd0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_reset32("abort");
    repeat (40) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);
    issue32(3'b000, 32'd3, 32'd3, "mul_3x3");
    drain32("post_abort");

    // Randomized traffic, including back-to-back issue.
    for (int i = 0; i < 120; i++) begin
      issue32(3'($urandom), rand_opnd(32), rand_opnd(32), $sformatf("rnd32_%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain32("rnd32");
  endtask

  task automatic seq8();
    issue8(3'b101, 8'd200, 8'd7, "divu8_200_7");
    issue8(3'b100, 8'h80, 8'hFF, "div8_ovf");
    issue8(3'b010, 8'hFF, 8'hFF, "mulhsu8_ones");
    for (int i = 0; i < 150; i++) begin
      issue8(3'($urandom), 8'(rand_opnd(8)), 8'(rand_opnd(8)), $sformatf("rnd8_%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain8("rnd8");
  endtask

  initial begin
    rst = 1'b1;  start = 1'b0;  op = '0;  a = '0;  b = '0;
    rst8 = 1'b1; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst8 = 1'b0;
    check_reset32("reset");
    check("reset8_result", {24'd0, res8}, 32'd0);
    check("reset8_busy", 32'(busy8), 32'd0);
    fork
      seq32();
      seq8();
    join
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
